alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational 32-bit ALU (a, b, f[2:0] -> y, zero) between two requesters.
//  Arbitrates round-robin, steers the winner's operands onto the ALU, and registers y/zero
//  into a one-entry response buffer with a valid/ready handshake.
//  Sits between the requesters (datapath ports, test sequencers) and the single ALU instance.
// PARAMETERS
//  WIDTH   32   operand/result width; must match the attached ALU
// PORTS
//  clk         in   1      system clock; all state updates on the rising edge
//  reset       in   1      synchronous, active-high reset
//  req0_valid  in   1      requester 0 has an operation pending
//  req0_ready  out  1      requester 0 operation accepted this cycle
//  req0_f      in   3      requester 0 ALU function code
//  req0_a      in   WIDTH  requester 0 operand a
//  req0_b      in   WIDTH  requester 0 operand b
//  req1_*      --   --     same set for requester 1
//  alu_f       out  3      to ALU f
//  alu_a       out  WIDTH  to ALU a
//  alu_b       out  WIDTH  to ALU b
//  alu_y       in   WIDTH  from ALU y
//  alu_zero    in   1      from ALU zero
//  rsp_valid   out  1      response buffer holds a result
//  rsp_ready   in   1      consumer accepts the response this cycle
//  rsp_id      out  1      requester that owns the response (0/1)
//  rsp_y       out  WIDTH  registered ALU result
//  rsp_zero    out  1      registered ALU zero flag
// BEHAVIOUR
//  - Reset (sync, active-high): rsp_valid=0, rsp_y=0, rsp_zero=0, rsp_id=0, last_id=1.
//    This drops any held response. No grant is issued in a reset cycle.
//  - States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
//  - can_issue = EMPTY | (FULL & rsp_ready). A drain and a new issue may occur in the same cycle.
//  - Grant, combinational, only when can_issue:
//    - Exactly one reqN_valid -> grant N.
//    - Both valid -> grant !last_id (strict alternation).
//    - None valid -> no grant.
//  - reqN_ready = grant to N. At most one ready per cycle. Never asserted while FULL & !rsp_ready.
//  - ALU steering: alu_f/a/b = granted requester's f/a/b; all zero when no grant.
//  - On a grant edge: rsp_y<=alu_y, rsp_zero<=alu_zero, rsp_id<=N, rsp_valid<=1, last_id<=N.
//    Latency: accepted op -> rsp_valid exactly 1 cycle later.
//  - FULL & rsp_ready & no grant -> EMPTY (rsp_valid<=0).
//  - FULL & !rsp_ready: rsp_* held bit-stable, no grant.
//  - Throughput: 1 op/cycle while rsp_ready=1.
//  - Requester rule: f/a/b held stable while valid & !ready.
//    The arbiter does not latch operands before grant.
//  - Function codes pass through unchecked; unused codes (011) yield whatever the ALU produces.
//  - A valid that drops before grant is simply not served. No starvation: a continuously
//    valid requester is granted within 2 issue slots.
// TESTING
//  1. req0 only, f=010 a=5 b=3, rsp_ready=1 -> next cycle rsp_valid=1 id=0 y=8 zero=0.
//  2. Both valid 4 cycles, rsp_ready=1 -> grants 0,1,0,1; responses id 0,1,0,1 on consecutive cycles.
//  3. rsp_ready=0 for 3 cycles with both valid -> rsp_* stable, req0/1_ready=0.
//     rsp_ready=1 -> drain plus new grant in the same cycle.
//  4. f=110 a=7 b=7 -> y=0 zero=1.
//     f=111 a=FFFFFFFF b=1 -> y=1 zero=0 (signed SLT).
//     f=000 a=F0F0F0F0 b=0FF00FF0 -> y=00F000F0.
//  5. reset during FULL with rsp_ready=0 -> next cycle rsp_valid=0.
//     Both valid after reset -> req0 granted first.
//  6. req1 alone valid 5 cycles, rsp_ready=1 -> 5 back-to-back responses, all id=1.
//     alu_* = 0 in idle cycles.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end for a single shared combinational ALU.
// Two requesters compete for the ALU. The winner's operands are steered onto the
// ALU in the same cycle, and the ALU result is captured into a one-entry response
// buffer that the consumer drains with a valid/ready handshake.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_f,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_f,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [2:0]       alu_f,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero
);

  // EMPTY: no result held; FULL: a result waits for the consumer.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_r;
  logic             last_id_r;
  logic             rsp_id_r;
  logic             rsp_zero_r;
  logic [WIDTH-1:0] rsp_y_r;

  logic             can_issue_s;
  logic             grant_s;
  logic             grant_id_s;

  // Decide whether the buffer can take a new op this cycle and which requester wins it
  always_comb begin
    can_issue_s = 1'b0;
    grant_s     = 1'b0;
    grant_id_s  = 1'b0;
    if (reset) begin
      // A reset cycle never hands out a grant.
      can_issue_s = 1'b0;
    end else begin
      case (state_r)
        EMPTY:   can_issue_s = 1'b1;
        FULL:    can_issue_s = rsp_ready;  // draining frees the slot in the same cycle
        default: can_issue_s = 1'b0;
      endcase
    end
    if (can_issue_s) begin
      case ({req1_valid, req0_valid})
        2'b01: begin
          grant_s    = 1'b1;
          grant_id_s = 1'b0;
        end
        2'b10: begin
          grant_s    = 1'b1;
          grant_id_s = 1'b1;
        end
        2'b11: begin
          // Contention: strictly alternate against whoever was served last.
          grant_s    = 1'b1;
          grant_id_s = ~last_id_r;
        end
        default: begin
          grant_s    = 1'b0;
          grant_id_s = 1'b0;
        end
      endcase
    end else begin
      grant_s    = 1'b0;
      grant_id_s = 1'b0;
    end
  end

  // Steer the granted requester's operation onto the ALU; park the ALU at zero when idle
  always_comb begin
    alu_f = 3'b000;
    alu_a = '0;
    alu_b = '0;
    if (grant_s) begin
      case (grant_id_s)
        1'b0: begin
          alu_f = req0_f;
          alu_a = req0_a;
          alu_b = req0_b;
        end
        1'b1: begin
          alu_f = req1_f;
          alu_a = req1_a;
          alu_b = req1_b;
        end
        default: begin
          alu_f = 3'b000;
          alu_a = '0;
          alu_b = '0;
        end
      endcase
    end else begin
      alu_f = 3'b000;
      alu_a = '0;
      alu_b = '0;
    end
  end

  assign req0_ready = grant_s & ~grant_id_s;
  assign req1_ready = grant_s &  grant_id_s;

  // Response buffer FSM: capture the ALU result on a grant, drain on consumer accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= EMPTY;
      rsp_y_r    <= '0;
      rsp_zero_r <= 1'b0;
      rsp_id_r   <= 1'b0;
      last_id_r  <= 1'b1;  // makes requester 0 the first winner under contention
    end else begin
      case (state_r)
        EMPTY: begin
          if (grant_s) begin
            state_r    <= FULL;
            rsp_y_r    <= alu_y;
            rsp_zero_r <= alu_zero;
            rsp_id_r   <= grant_id_s;
            last_id_r  <= grant_id_s;
          end else begin
            state_r <= EMPTY;
          end
        end
        FULL: begin
          if (grant_s) begin
            // Drain and refill in one cycle keeps throughput at one op per cycle.
            state_r    <= FULL;
            rsp_y_r    <= alu_y;
            rsp_zero_r <= alu_zero;
            rsp_id_r   <= grant_id_s;
            last_id_r  <= grant_id_s;
          end else if (rsp_ready) begin
            state_r <= EMPTY;
          end else begin
            // Back-pressure: hold the response bit-stable.
            state_r <= FULL;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

  assign rsp_valid = (state_r == FULL);
  assign rsp_id    = rsp_id_r;
  assign rsp_y     = rsp_y_r;
  assign rsp_zero  = rsp_zero_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU sits on the alu_* port, directed tasks
// cover the documented scenarios, and a randomized phase compares against a
// transaction-level model of the arbiter.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0v, r1v;
  logic        r0_ready, r1_ready;
  logic [2:0]  r0f, r1f;
  logic [31:0] r0a, r0b, r1a, r1b;
  logic [2:0]  alu_f;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_y;

  int checks = 0;
  int errors = 0;

  // Model state: the one-entry response slot plus who was served last.
  logic        m_valid, m_id, m_zero, m_last;
  logic [31:0] m_y;
  // Model prediction for the current cycle.
  logic        p_grant, p_id;

  always #5 clk = ~clk;

  // Reference ALU: AND, OR, ADD, (unused), AND-NOT, OR-NOT, SUB, signed SLT.
  function automatic logic [31:0] alu_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_y    = alu_ref(alu_f, alu_a, alu_b);
  assign alu_zero = (alu_y == 32'd0);

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(r0_ready), .req0_f(r0f), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(r1_ready), .req1_f(r1f), .req1_a(r1a), .req1_b(r1b),
    .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_zero(rsp_zero)
  );

  // Which requester (if any) gets served this cycle, from the arbitration rules.
  task automatic predict();
    logic slot_free;
    slot_free = !reset && (!m_valid || rsp_ready);
    p_grant = 1'b0;
    p_id    = 1'b0;
    if (slot_free && r0v && r1v) begin
      p_grant = 1'b1;
      p_id    = (m_last == 1'b1) ? 1'b0 : 1'b1;  // whoever was not served last
    end else if (slot_free && r0v) begin
      p_grant = 1'b1;
      p_id    = 1'b0;
    end else if (slot_free && r1v) begin
      p_grant = 1'b1;
      p_id    = 1'b1;
    end
  endtask

  // Advance one clock and apply the predicted transaction to the model.
  task automatic commit();
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_y = 32'd0; m_zero = 1'b0; m_id = 1'b0; m_last = 1'b1;
    end else if (p_grant) begin
      m_y     = p_id ? alu_ref(r1f, r1a, r1b) : alu_ref(r0f, r0a, r0b);
      m_zero  = (m_y == 32'd0);
      m_id    = p_id;
      m_last  = p_id;
      m_valid = 1'b1;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rsp_ready = 1'b0;
    r0v = 1'b1; r1v = 1'b1;
    r0f = 3'b010; r0a = 32'd1; r0b = 32'd2; r1f = 3'b010; r1a = 32'd3; r1b = 32'd4;
    #1; predict();
    checks++;
    if ({r1_ready, r0_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_no_grant: ready=%b expected 00", {r1_ready, r0_ready});
    end
    commit(); predict(); commit();
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_y} !== 35'd0) begin
      errors++; $display("FAIL reset_state: v=%b id=%b z=%b y=%h expected all zero", rsp_valid, rsp_id, rsp_zero, rsp_y);
    end
    reset = 1'b0; r0v = 1'b0; r1v = 1'b0;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1; r1v = 1'b0;
    r0v = 1'b1; r0f = 3'b010; r0a = 32'd5; r0b = 32'd3;
    #1; predict();
    checks++;
    if ({r1_ready, r0_ready, alu_f, alu_a, alu_b} !== {2'b01, 3'b010, 32'd5, 32'd3}) begin
      errors++; $display("FAIL single_grant: ready=%b f=%b a=%h b=%h expected 01/010/5/3", {r1_ready, r0_ready}, alu_f, alu_a, alu_b);
    end
    commit(); r0v = 1'b0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_y} !== {1'b1, 1'b0, 1'b0, 32'd8}) begin
      errors++; $display("FAIL single_rsp: v=%b id=%b z=%b y=%h expected 1/0/0/8", rsp_valid, rsp_id, rsp_zero, rsp_y);
    end
  endtask

  task automatic test_alternation();
    reset = 1'b1; #1; predict(); commit(); reset = 1'b0;
    rsp_ready = 1'b1;
    r0v = 1'b1; r0f = 3'b010; r0a = 32'd5;  r0b = 32'd3;   // y = 8
    r1v = 1'b1; r1f = 3'b110; r1a = 32'd20; r1b = 32'd6;   // y = 14
    for (int i = 0; i < 4; i++) begin
      #1; predict();
      checks++;
      if ({r1_ready, r0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL alt_grant[%0d]: ready=%b", i, {r1_ready, r0_ready});
      end
      commit();
      checks++;
      if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'(i % 2), ((i % 2 == 0) ? 32'd8 : 32'd14)}) begin
        errors++; $display("FAIL alt_rsp[%0d]: v=%b id=%b y=%h", i, rsp_valid, rsp_id, rsp_y);
      end
    end
  endtask

  task automatic test_backpressure();
    // Buffer holds id=1 y=14; both requesters still valid.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; predict();
      checks++;
      if ({r1_ready, r0_ready} !== 2'b00) begin
        errors++; $display("FAIL bp_ready[%0d]: ready=%b expected 00", i, {r1_ready, r0_ready});
      end
      commit();
      checks++;
      if ({rsp_valid, rsp_id, rsp_zero, rsp_y} !== {1'b1, 1'b1, 1'b0, 32'd14}) begin
        errors++; $display("FAIL bp_hold[%0d]: v=%b id=%b z=%b y=%h expected 1/1/0/e", i, rsp_valid, rsp_id, rsp_zero, rsp_y);
      end
    end
    rsp_ready = 1'b1;
    #1; predict();
    checks++;
    if ({r1_ready, r0_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release_grant: ready=%b expected 01", {r1_ready, r0_ready});
    end
    commit();
    checks++;
    if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b0, 32'd8}) begin
      errors++; $display("FAIL bp_release_rsp: v=%b id=%b y=%h expected 1/0/8", rsp_valid, rsp_id, rsp_y);
    end
    r0v = 1'b0; r1v = 1'b0;
  endtask

  task automatic test_alu_codes();
    logic [2:0]  tf[4];
    logic [31:0] ta[4], tb[4], ty[4];
    tf[0] = 3'b110; ta[0] = 32'd7;          tb[0] = 32'd7;          ty[0] = 32'd0;
    tf[1] = 3'b111; ta[1] = 32'hFFFF_FFFF;  tb[1] = 32'd1;          ty[1] = 32'd1;
    tf[2] = 3'b000; ta[2] = 32'hF0F0_F0F0;  tb[2] = 32'h0FF0_0FF0;  ty[2] = 32'h00F0_00F0;
    tf[3] = 3'b111; ta[3] = 32'd1;          tb[3] = 32'hFFFF_FFFF;  ty[3] = 32'd0;
    rsp_ready = 1'b1; r0v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r1v = 1'b1; r1f = tf[i]; r1a = ta[i]; r1b = tb[i];
      #1; predict(); commit();
      checks++;
      if ({rsp_valid, rsp_id, rsp_zero, rsp_y} !== {1'b1, 1'b1, (ty[i] == 32'd0), ty[i]}) begin
        errors++; $display("FAIL alu_code[%0d]: v=%b id=%b z=%b y=%h expected y=%h", i, rsp_valid, rsp_id, rsp_zero, rsp_y, ty[i]);
      end
    end
    r1v = 1'b0;
  endtask

  task automatic test_reset_full();
    rsp_ready = 1'b0; r0v = 1'b1; r0f = 3'b001; r0a = 32'h10; r0b = 32'h01;
    #1; predict(); commit();   // slot was draining-free? earlier rsp held with ready=0 -> no grant
    reset = 1'b1;
    #1; predict(); commit();
    checks++;
    if ({rsp_valid, rsp_y} !== 33'd0) begin
      errors++; $display("FAIL reset_full: v=%b y=%h expected 0/0", rsp_valid, rsp_y);
    end
    reset = 1'b0; rsp_ready = 1'b1;
    r0v = 1'b1; r1v = 1'b1; r1f = 3'b010; r1a = 32'd1; r1b = 32'd1;
    #1; predict();
    checks++;
    if ({r1_ready, r0_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_first_grant: ready=%b expected 01", {r1_ready, r0_ready});
    end
    commit();
    checks++;
    if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b0, 32'h11}) begin
      errors++; $display("FAIL reset_first_rsp: v=%b id=%b y=%h expected 1/0/11", rsp_valid, rsp_id, rsp_y);
    end
    r0v = 1'b0; r1v = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_y;
    rsp_ready = 1'b1; r0v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r1v = 1'b1; r1f = 3'b010; r1a = $urandom; r1b = 32'(i);
      exp_y = r1a + 32'(i);
      #1; predict();
      checks++;
      if ({r1_ready, r0_ready} !== 2'b10) begin
        errors++; $display("FAIL b2b_grant[%0d]: ready=%b expected 10", i, {r1_ready, r0_ready});
      end
      commit();
      checks++;
      if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 1'b1, exp_y}) begin
        errors++; $display("FAIL b2b_rsp[%0d]: v=%b id=%b y=%h expected 1/1/%h", i, rsp_valid, rsp_id, rsp_y, exp_y);
      end
    end
    r1v = 1'b0;
    #1; predict();
    checks++;
    if ({r1_ready, r0_ready, alu_f, alu_a, alu_b} !== 69'd0) begin
      errors++; $display("FAIL idle_alu: ready=%b f=%b a=%h b=%h expected zeros", {r1_ready, r0_ready}, alu_f, alu_a, alu_b);
    end
    commit();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL idle_drain: v=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_random();
    logic g0, g1;
    logic [2:0]  ef;
    logic [31:0] ea, eb;
    g0 = 1'b1; g1 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(39, 0) == 0);
      rsp_ready = ($urandom_range(3, 0) != 0);
      // Requesters keep an unserved op stable; otherwise pick something new.
      if (!r0v || g0) begin
        r0v = ($urandom_range(9, 0) < 6); r0f = 3'($urandom_range(7, 0)); r0a = $urandom; r0b = $urandom;
        if ($urandom_range(3, 0) == 0) r0b = r0a;
      end
      if (!r1v || g1) begin
        r1v = ($urandom_range(9, 0) < 6); r1f = 3'($urandom_range(7, 0)); r1a = $urandom; r1b = $urandom;
      end
      #1; predict();
      ef = 3'b000; ea = 32'd0; eb = 32'd0;
      if (p_grant && p_id)  begin ef = r1f; ea = r1a; eb = r1b; end
      if (p_grant && !p_id) begin ef = r0f; ea = r0a; eb = r0b; end
      checks++;
      if ({r1_ready, r0_ready, alu_f, alu_a, alu_b} !== {p_grant & p_id, p_grant & ~p_id, ef, ea, eb}) begin
        errors++; $display("FAIL rand_issue[%0d]: ready=%b f=%b a=%h b=%h expected ready=%b f=%b a=%h b=%h",
                           i, {r1_ready, r0_ready}, alu_f, alu_a, alu_b, {p_grant & p_id, p_grant & ~p_id}, ef, ea, eb);
      end
      g0 = p_grant & ~p_id;
      g1 = p_grant & p_id;
      commit();
      checks++;
      if ({rsp_valid, rsp_id, rsp_zero, rsp_y} !== {m_valid, m_id, m_zero, m_y}) begin
        errors++; $display("FAIL rand_rsp[%0d]: v=%b id=%b z=%b y=%h expected v=%b id=%b z=%b y=%h",
                           i, rsp_valid, rsp_id, rsp_zero, rsp_y, m_valid, m_id, m_zero, m_y);
      end
    end
    reset = 1'b0; r0v = 1'b0; r1v = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b0; r0v = 1'b0; r1v = 1'b0;
    r0f = 3'b000; r0a = 32'd0; r0b = 32'd0; r1f = 3'b000; r1a = 32'd0; r1b = 32'd0;
    m_valid = 1'b0; m_id = 1'b0; m_zero = 1'b0; m_last = 1'b1; m_y = 32'd0;
    p_grant = 1'b0; p_id = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_alternation();
    test_backpressure();
    test_alu_codes();
    test_reset_full();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
